// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor constants: opcodes, default sizes, register fields
package proc_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_NAND = 3'd2,
        OP_LUI  = 3'd3,
        OP_SW   = 3'd4,
        OP_LW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_JALR = 3'd7
    } opcode_e;

    localparam int RA_LSB = 10;
    localparam int RB_LSB = 7;
    localparam int RC_LSB = 0;
    localparam int RF_W   = 3;

    function automatic logic [RF_W-1:0] reg_field(input logic [15:0] instr, input int lsb);
        return instr[lsb +: RF_W];
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy tracking, claim handshake and per-port busy/bypass lookup
module regfile_scoreboard
    import proc_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] i_rd_addr,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic                 i_claim_valid,
    input  logic [AW-1:0]        i_claim_addr,
    output logic [NUM_RD-1:0]    o_rd_busy,
    output logic [NUM_RD-1:0]    o_rd_fwd,
    output logic [NUM_RD-1:0]    o_rd_zero,
    output logic                 o_claim_ready,
    output logic [NUM_REGS-1:0]  o_busy_vec
);

    logic [NUM_REGS-1:0] r_busy;
    logic                w_claim_zero;
    logic                w_claim_take;
    logic [AW-1:0]       w_addr;

    assign w_claim_zero  = (ZERO_REG != 0) && (i_claim_addr == '0);
    // A write retiring the current owner in this cycle lets the next producer claim immediately.
    assign o_claim_ready = w_claim_zero || !r_busy[i_claim_addr]
                         || ((BYPASS != 0) && i_wr_en && (i_wr_addr == i_claim_addr));
    assign w_claim_take  = i_claim_valid && o_claim_ready && !w_claim_zero;
    assign o_busy_vec    = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (i_wr_en)
                r_busy[i_wr_addr] <= 1'b0;
            // Claim is applied last so a same-edge write never clears a fresh claim.
            if (w_claim_take)
                r_busy[i_claim_addr] <= 1'b1;
        end
    end

    always_comb begin
        o_rd_busy = '0;
        o_rd_fwd  = '0;
        o_rd_zero = '0;
        w_addr    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_addr       = i_rd_addr[i*AW +: AW];
            o_rd_zero[i] = (ZERO_REG != 0) && (w_addr == '0);
            o_rd_fwd[i]  = (BYPASS != 0) && i_wr_en && (i_wr_addr == w_addr);
            o_rd_busy[i] = !o_rd_zero[i] && !o_rd_fwd[i] && r_busy[w_addr];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with zero register, write bypass and scoreboard
module regfile_sb
    import proc_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_valid,
    input  logic [AW-1:0]            claim_addr,
    output logic                     claim_ready,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];
    logic [NUM_RD-1:0] w_rd_fwd;
    logic [NUM_RD-1:0] w_rd_zero;
    logic              w_wr_keep;

    assign w_wr_keep = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_mem[i] <= '0;
        end else if (w_wr_keep) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_rd_zero[i])
                rd_data[i*DATA_W +: DATA_W] = '0;
            else if (w_rd_fwd[i])
                rd_data[i*DATA_W +: DATA_W] = wr_data;
            else
                rd_data[i*DATA_W +: DATA_W] = r_mem[rd_addr[i*AW +: AW]];
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .i_rd_addr     (rd_addr),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_claim_valid (claim_valid),
        .i_claim_addr  (claim_addr),
        .o_rd_busy     (rd_busy),
        .o_rd_fwd      (w_rd_fwd),
        .o_rd_zero     (w_rd_zero),
        .o_claim_ready (claim_ready),
        .o_busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - bench for regfile_sb: default instance and wide no-bypass/no-zero instance
module tb_regfile_sb;

    localparam logic [1:0] ZR = 2'b01;
    localparam logic [1:0] BP = 2'b01;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [5:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en;
    logic [2:0]  a_wr_addr;
    logic [15:0] a_wr_data;
    logic        a_cv;
    logic [2:0]  a_ca;
    logic        a_cr;
    logic [7:0]  a_bv;

    logic [14:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic        b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_cv;
    logic [4:0]  b_ca;
    logic        b_cr;
    logic [31:0] b_bv;

    regfile_sb u_a (
        .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .claim_valid(a_cv), .claim_addr(a_ca), .claim_ready(a_cr), .busy_vec(a_bv)
    );

    regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .claim_valid(b_cv), .claim_addr(b_ca), .claim_ready(b_cr), .busy_vec(b_bv)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Reference state: one array of register values and busy flags per instance.
    logic [31:0] m_mem  [2][32];
    logic [31:0] m_busy [2];
    logic        chk_on = 1'b0;

    function automatic logic [32:0] exp_rd(input int d, input int a, input logic we,
                                           input int wa, input logic [31:0] wd);
        if (ZR[d] && a == 0) return 33'd0;
        if (BP[d] && we && wa == a) return {1'b0, wd};
        return {m_busy[d][a], m_mem[d][a]};
    endfunction

    function automatic logic exp_cr(input int d, input int ca, input logic we, input int wa);
        return (ZR[d] && ca == 0) || !m_busy[d][ca] || (BP[d] && we && wa == ca);
    endfunction

    task automatic model_edge(input int d, input logic r, input logic we, input int wa,
                              input logic [31:0] wd, input logic cv, input int ca);
        logic ready;
        if (r) begin
            for (int i = 0; i < 32; i++) m_mem[d][i] = '0;
            m_busy[d] = '0;
            return;
        end
        ready = exp_cr(d, ca, we, wa);
        if (we && !(ZR[d] && wa == 0)) begin
            m_mem[d][wa]  = wd;
            m_busy[d][wa] = 1'b0;
        end
        if (cv && ready && !(ZR[d] && ca == 0)) m_busy[d][ca] = 1'b1;
    endtask

    always @(posedge clk) begin
        model_edge(0, rst, a_wr_en, int'(a_wr_addr), {16'd0, a_wr_data}, a_cv, int'(a_ca));
        model_edge(1, rst, b_wr_en, int'(b_wr_addr), b_wr_data, b_cv, int'(b_ca));
        if (rst) chk_on <= 1'b1;
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (chk_on) begin
            for (int p = 0; p < 2; p++) begin
                e = exp_rd(0, int'(a_rd_addr[p*3 +: 3]), a_wr_en, int'(a_wr_addr), {16'd0, a_wr_data});
                chk("model_a_rd_data", a_rd_data[p*16 +: 16], e[15:0]);
                chk("model_a_rd_busy", a_rd_busy[p], e[32]);
            end
            chk("model_a_claim_ready", a_cr, exp_cr(0, int'(a_ca), a_wr_en, int'(a_wr_addr)));
            chk("model_a_busy_vec", a_bv, m_busy[0][7:0]);
            for (int p = 0; p < 3; p++) begin
                e = exp_rd(1, int'(b_rd_addr[p*5 +: 5]), b_wr_en, int'(b_wr_addr), b_wr_data);
                chk("model_b_rd_data", b_rd_data[p*32 +: 32], e[31:0]);
                chk("model_b_rd_busy", b_rd_busy[p], e[32]);
            end
            chk("model_b_claim_ready", b_cr, exp_cr(1, int'(b_ca), b_wr_en, int'(b_wr_addr)));
            chk("model_b_busy_vec", b_bv, m_busy[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_wr_en = 1'b0;
        a_cv    = 1'b0;
    endtask

    task automatic idle_b();
        b_wr_en = 1'b0;
        b_cv    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 16'hFFFF; a_cv = 1'b1; a_ca = 3'd5; a_rd_addr = '0;
        b_wr_en = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'hFFFF_FFFF; b_cv = 1'b1; b_ca = 5'd7; b_rd_addr = '0;
        tick();
        rst = 1'b0;
        idle_a();
        idle_b();
        #1;
        chk("rst_a_busy_vec", a_bv, 8'h00);
        chk("rst_a_claim_ready", a_cr, 1'b1);
        chk("rst_b_busy_vec", b_bv, 32'h0);
        chk("rst_b_claim_ready", b_cr, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a_rd_addr = {3'(7 - i), 3'(i)};
            b_rd_addr = {5'(31 - i), 5'(16 + i), 5'(i)};
            #1;
            chk("rst_a_read", a_rd_data, 32'h0);
            chk("rst_b_read", b_rd_data, 96'h0);
            tick();
        end

        // Bypass on instance A: same-cycle and next-cycle read of r3
        a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 16'h1234; a_rd_addr = {3'd0, 3'd3};
        #1 chk("a_bypass_same", a_rd_data[15:0], 16'h1234);
        tick(); idle_a();
        #1 chk("a_bypass_next", a_rd_data[15:0], 16'h1234);

        // Zero register on A
        a_wr_en = 1'b1; a_wr_addr = 3'd0; a_wr_data = 16'hBEEF; a_cv = 1'b1; a_ca = 3'd0; a_rd_addr = 6'd0;
        #1;
        chk("a_zero_ready", a_cr, 1'b1);
        chk("a_zero_same", a_rd_data[31:16], 16'h0);
        tick(); idle_a();
        #1;
        chk("a_zero_read", a_rd_data, 32'h0);
        chk("a_zero_busy", a_bv[0], 1'b0);

        // Scoreboard lifecycle on r5
        a_cv = 1'b1; a_ca = 3'd5;
        tick(); a_cv = 1'b0; a_rd_addr = {3'd5, 3'd5};
        #1;
        chk("a_claim_busy_vec", a_bv, 8'h20);
        chk("a_claim_rd_busy", a_rd_busy, 2'b11);
        a_cv = 1'b1; a_ca = 3'd5;
        #1 chk("a_second_claim_ready", a_cr, 1'b0);
        tick(); a_cv = 1'b0;
        #1 chk("a_second_claim_busy_vec", a_bv, 8'h20);
        a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 16'h00AA;
        tick(); idle_a();
        #1;
        chk("a_release_busy_vec", a_bv, 8'h00);
        chk("a_release_data", a_rd_data, {16'h00AA, 16'h00AA});
        chk("a_release_rd_busy", a_rd_busy, 2'b00);

        // Simultaneous write and re-claim of busy r5
        a_cv = 1'b1; a_ca = 3'd5;
        tick(); a_cv = 1'b0;
        a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 16'h5555; a_cv = 1'b1; a_ca = 3'd5;
        #1;
        chk("a_simul_ready", a_cr, 1'b1);
        chk("a_simul_same_data", a_rd_data, {16'h5555, 16'h5555});
        chk("a_simul_same_busy", a_rd_busy, 2'b00);
        tick(); idle_a();
        #1;
        chk("a_simul_busy_vec", a_bv, 8'h20);
        chk("a_simul_data", a_rd_data, {16'h5555, 16'h5555});
        chk("a_simul_rd_busy", a_rd_busy, 2'b11);
        a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 16'h0F0F;
        tick(); idle_a();
        #1 chk("a_final_busy_vec", a_bv, 8'h00);

        // Instance B: no bypass
        b_wr_en = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'h0000_1234; b_rd_addr = {5'd0, 5'd0, 5'd3};
        #1 chk("b_nobypass_same", b_rd_data[31:0], 32'h0);
        tick(); idle_b();
        #1 chk("b_nobypass_next", b_rd_data[31:0], 32'h0000_1234);

        // Instance B: r0 is an ordinary register
        b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 32'h0000_BEEF; b_cv = 1'b1; b_ca = 5'd0;
        tick(); idle_b(); b_rd_addr = '0;
        #1;
        chk("b_r0_data", b_rd_data[31:0], 32'h0000_BEEF);
        chk("b_r0_busy", b_bv[0], 1'b1);

        // Wide sweep: r31 on all three ports
        b_wr_en = 1'b1; b_wr_addr = 5'd31; b_wr_data = 32'hDEAD_BEEF; b_rd_addr = {5'd31, 5'd31, 5'd31};
        #1 chk("b_r31_same", b_rd_data, 96'h0);
        tick(); idle_b();
        #1 chk("b_r31_all_ports", b_rd_data, {3{32'hDEAD_BEEF}});

        // Without bypass a retiring write does not free the register for a same-cycle claim
        b_cv = 1'b1; b_ca = 5'd5;
        tick(); b_cv = 1'b0;
        b_wr_en = 1'b1; b_wr_addr = 5'd5; b_wr_data = 32'h77; b_cv = 1'b1; b_ca = 5'd5;
        #1 chk("b_busy_claim_ready", b_cr, 1'b0);
        tick(); idle_b();
        #1 chk("b_busy_after_write", b_bv[5], 1'b0);

        // Reset while claims are outstanding
        b_cv = 1'b1; b_ca = 5'd9;
        tick(); idle_b();
        #1 chk("b_pre_reset_busy_vec", b_bv, 32'h0000_0201);
        rst = 1'b1; b_cv = 1'b1; b_ca = 5'd12; b_wr_en = 1'b1; b_wr_addr = 5'd31; b_wr_data = 32'h1;
        tick();
        rst = 1'b0; idle_b();
        #1;
        chk("b_reset_busy_vec", b_bv, 32'h0);
        chk("b_reset_claim_ready", b_cr, 1'b1);
        chk("b_reset_data", b_rd_data, 96'h0);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated write scoreboard for the 16-bit processor datapath. It generalises the fixed 8×16 register array to configurable width, depth and read-port count. It adds a hardwired zero register, same-cycle write-to-read bypass, and per-register busy tracking for multi-cycle producers such as loads. It sits between decode, which claims destinations and reads operands, and writeback, which writes results and releases destinations.

## Interface
- DATA_W, 16, register width in bits
- NUM_REGS, 8, register count; power of two, ≥2
- NUM_RD, 2, number of independent read ports, 1..4
- ZERO_REG, 1, 1 = r0 reads 0, writes/claims to r0 ignored
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see pre-edge contents
- AW (derived), $clog2(NUM_REGS)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*AW  read addresses; port i = bits [i*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  1 = addressed register has an outstanding producer
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  DATA_W  writeback value
- claim_valid  in  1  decode requests ownership of claim_addr
- claim_addr  in  AW  destination being claimed
- claim_ready  out  1  claim can be accepted this cycle
- busy_vec  out  NUM_REGS  registered busy bits, debug/stall logic

## Operation
- Storage: NUM_REGS × DATA_W flops; busy: NUM_REGS flops.
- Write: on the edge with wr_en=1, reg[wr_addr] ← wr_data and busy[wr_addr] ← 0. Exception: a same-cycle accepted claim to the same address leaves busy set.
- Claim is accepted when claim_valid && claim_ready. On acceptance, busy[claim_addr] ← 1.
- claim_ready = !busy[claim_addr], or BYPASS=1 && wr_en && wr_addr==claim_addr. This means at most one outstanding producer per register; no WAW.
- Read port i returns data and busy for rd_addr[i]:
  - BYPASS=1 and wr_en && wr_addr==rd_addr[i]: rd_data=wr_data, rd_busy=0.
  - Otherwise: rd_data=reg[rd_addr[i]], rd_busy=busy[rd_addr[i]].
- ZERO_REG=1, address 0:
  - rd_data=0 and rd_busy=0 always.
  - Writes are dropped.
  - claim_ready=1 and claims are dropped; busy[0] stays 0.
- A write to a non-busy register is legal. It updates data and leaves busy at 0.
- All read ports are independent. Identical addresses on several ports return identical results.

## Timing
- Reset: on the clk edge with rst=1, all registers ← 0 and all busy ← 0; rst overrides concurrent wr_en/claim. busy_vec=0 from the first cycle after reset. claim_ready=1 whenever rst was asserted on the previous edge.
- Read latency 0: combinational from rd_addr, wr_*, and state.
- Write/claim latency 1: visible in state on the next edge.
- rd_data/rd_busy/claim_ready have no combinational path from claim_valid.
- Address width is exact AW; NUM_REGS is a power of two, so no out-of-range handling is needed.

## Structure
- Shared package proc_pkg:
  - opcode constants (ADD, ADDI, NAND, LUI, LW, SW, BEQ, JALR);
  - default DATA_W=16 and NUM_REGS=8;
  - register-field bit positions (rA 12:10, rB 9:7, rC 2:0).
- One sub-module: regfile_scoreboard. It holds the busy vector, claim_ready, and per-port busy lookup with bypass. The data array stays in regfile_sb.

## Test plan
- Reset then read: pulse rst with wr_en=1 and wr_data=16'hFFFF -> every address reads 0, busy_vec=0, claim_ready=1.
- Write/read, BYPASS=1: write r3=16'h1234, with rd_addr port0=3 in the same cycle -> rd_data0=16'h1234 that cycle and the next. With BYPASS=0 -> the old value in the same cycle, 16'h1234 the next.
- Zero register: write r0=16'hBEEF and claim r0 -> r0 reads 0, busy_vec[0]=0. With ZERO_REG=0 -> reads 16'hBEEF.
- Scoreboard lifecycle: claim r5 -> busy_vec=8'h20, rd_busy for r5=1. A second claim of r5 sees claim_ready=0 and is not accepted. Write r5=16'h00AA -> busy_vec=0, r5=16'h00AA.
- Simultaneous write and claim of r5 while busy -> claim_ready=1 (BYPASS=1), data=write value, busy_vec[5] stays 1.
- Parameter sweep: DATA_W=32, NUM_REGS=32, NUM_RD=3. Write r31=32'hDEADBEEF, read it on all three ports -> all three return 32'hDEADBEEF. Reset mid-claim -> busy cleared.
